si4463_status_out: RTL

Parametrised multi-channel status-output driver for the Si4463 radio board, replacing the fixed constant-high test output. Each of NCH output pins is independently programmable as static low, static high, free-running blink or retriggerable one-shot pulse. All timing derives from one shared prescaler tick. The block drives board status LEDs and debug/strobe pins from the radio control logic.

---
 rtl/si4463_status_out_if.sv | 26 ++
 rtl/si4463_status_out.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/si4463_status_out_if.sv
// Configuration, trigger and status bundle for the Si4463 status-output driver.
// The master side is the radio control logic and the slave side is the driver.
interface si4463_status_out_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic             cfg_we;
   logic [CH_W-1:0]  cfg_ch;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_len;
   logic [NCH-1:0]   trig;
   logic [NCH-1:0]   out;
   logic [NCH-1:0]   busy;

   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_len, trig,
      input  out, busy
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_mode, cfg_len, trig,
      output out, busy
   );
endinterface

// File: rtl/si4463_status_out.sv
// Multi-channel status-output driver: each pin is static low/high, blink or
// retriggerable one-shot pulse, all timed from one shared prescaler tick.
module si4463_status_out #(
   parameter int         NCH        = 4,
   parameter int         TICK_DIV   = 50000,
   parameter int         CNT_W      = 8,
   parameter logic [1:0] RESET_MODE = 2'b01
) (
   input logic                clk,
   input logic                rst_n,
   si4463_status_out_if.slave bus
);
   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PULSE = 2'b11
   } mode_t;

   localparam int            PS_W      = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam mode_t         RST_MODE  = mode_t'(RESET_MODE);
   localparam logic          RST_OUT   = (RESET_MODE == 2'b01) || (RESET_MODE == 2'b10);

   logic [PS_W-1:0]  ps_q;
   logic             tick;

   mode_t            mode_q [NCH];
   mode_t            mode_d [NCH];
   logic [CNT_W-1:0] len_q  [NCH];
   logic [CNT_W-1:0] len_d  [NCH];
   logic [CNT_W-1:0] cnt_q  [NCH];
   logic [CNT_W-1:0] cnt_d  [NCH];
   logic [NCH-1:0]   out_q, out_d;
   logic [NCH-1:0]   busy_q, busy_d;
   logic [NCH-1:0]   wr;

   assign tick     = (ps_q == PS_LAST);
   assign bus.out  = out_q;
   assign bus.busy = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q <= '0;
      end else if (tick) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_q + 1'b1;
      end
   end

   // Out-of-range channel indices match no channel, so they are dropped here.
   always_comb begin
      wr = '0;
      for (int i = 0; i < NCH; i++) begin
         wr[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);
      end
   end

   always_comb begin
      out_d  = out_q;
      busy_d = busy_q;
      for (int i = 0; i < NCH; i++) begin
         mode_d[i] = mode_q[i];
         len_d[i]  = len_q[i];
         cnt_d[i]  = cnt_q[i];
      end

      for (int i = 0; i < NCH; i++) begin
         if (wr[i]) begin
            // A write masks both the trigger and any tick in the same cycle.
            mode_d[i] = mode_t'(bus.cfg_mode);
            len_d[i]  = bus.cfg_len;
            cnt_d[i]  = '0;
            busy_d[i] = 1'b0;
            out_d[i]  = (bus.cfg_mode == 2'b01) || (bus.cfg_mode == 2'b10);
         end else begin
            case (mode_q[i])
               MODE_OFF: begin
                  out_d[i]  = 1'b0;
                  busy_d[i] = 1'b0;
               end
               MODE_ON: begin
                  out_d[i]  = 1'b1;
                  busy_d[i] = 1'b0;
               end
               MODE_BLINK: begin
                  busy_d[i] = 1'b0;
                  if (tick) begin
                     if (cnt_q[i] == len_q[i]) begin
                        out_d[i] = ~out_q[i];
                        cnt_d[i] = '0;
                     end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                     end
                  end
               end
               MODE_PULSE: begin
                  if (!busy_q[i]) begin
                     out_d[i] = 1'b0;
                     if (bus.trig[i] && (len_q[i] != '0)) begin
                        out_d[i]  = 1'b1;
                        busy_d[i] = 1'b1;
                        cnt_d[i]  = len_q[i];
                     end
                  end else if (bus.trig[i]) begin
                     cnt_d[i] = len_q[i];
                  end else if (tick) begin
                     if (cnt_q[i] == CNT_W'(1)) begin
                        cnt_d[i]  = '0;
                        out_d[i]  = 1'b0;
                        busy_d[i] = 1'b0;
                     end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= {NCH{RST_OUT}};
         busy_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            mode_q[i] <= RST_MODE;
            len_q[i]  <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         out_q  <= out_d;
         busy_q <= busy_d;
         for (int i = 0; i < NCH; i++) begin
            mode_q[i] <= mode_d[i];
            len_q[i]  <= len_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end
endmodule
